// File: rtl/cozy_mem_pkg.sv
// Shared definitions for the Cozy memory arbiter slice.
//   COZY_ADDR_W / COZY_DATA_W / COZY_BWE_W : memory bus widths
//   gnt_e                                  : which port owns the memory this cycle
package cozy_mem_pkg;
    localparam int COZY_ADDR_W = 16;
    localparam int COZY_DATA_W = 16;
    localparam int COZY_BWE_W  = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_VID  = 2'd2
    } gnt_e;
endpackage

// File: rtl/cozy_mem_arbiter_if.sv
// Requester-side bundles for the Cozy memory arbiter.
//   cozy_mem_rw_if : read/write port (CPU)  - req/addr/wdata/bwe in, ack/rvalid/rdata out
//   cozy_mem_rd_if : read-only port (video) - req/addr in, ack/rvalid/rdata out
// modport master = requester side, modport slave = arbiter side.
interface cozy_mem_rw_if;
    import cozy_mem_pkg::*;
    logic                   req;
    logic [COZY_ADDR_W-1:0] addr;
    logic [COZY_DATA_W-1:0] wdata;
    logic [COZY_BWE_W-1:0]  bwe;
    logic                   ack;
    logic                   rvalid;
    logic [COZY_DATA_W-1:0] rdata;

    modport master (output req, addr, wdata, bwe, input ack, rvalid, rdata);
    modport slave  (input req, addr, wdata, bwe, output ack, rvalid, rdata);
endinterface

interface cozy_mem_rd_if;
    import cozy_mem_pkg::*;
    logic                   req;
    logic [COZY_ADDR_W-1:0] addr;
    logic                   ack;
    logic                   rvalid;
    logic [COZY_DATA_W-1:0] rdata;

    modport master (output req, addr, input ack, rvalid, rdata);
    modport slave  (input req, addr, output ack, rvalid, rdata);
endinterface

// File: rtl/cozy_mem_starve_ctr.sv
// Saturating starvation counter for the CPU port.
//   clk, rst : clock, async active-high reset
//   waiting  : CPU is requesting and was not served this cycle
//   served   : CPU was acked this cycle
//   starved  : counter has reached STARVE_LIMIT, CPU must win next grant
module cozy_mem_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic served,
    output logic starved
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (served || !waiting)
            cnt_d = 4'd0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end

    assign starved = (cnt_q == LIMIT);
endmodule

// File: rtl/cozy_mem_arbiter.sv
// Two-port arbiter in front of the single-port Cozy memory.
// Video has priority; the CPU overrides it once starved for STARVE_LIMIT cycles.
//   clk, rst           : clock, async active-high reset
//   cpu (rw slave)     : CPU read/write port
//   vid (rd slave)     : video text-fetch read port
//   mem_addr/din/bwe   : to memory
//   mem_dout           : combinational read data from memory
module cozy_mem_arbiter
    import cozy_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    cozy_mem_rw_if.slave           cpu,
    cozy_mem_rd_if.slave           vid,
    output logic [COZY_ADDR_W-1:0] mem_addr,
    output logic [COZY_DATA_W-1:0] mem_din,
    output logic [COZY_BWE_W-1:0]  mem_bwe,
    input  logic [COZY_DATA_W-1:0] mem_dout
);
    gnt_e gnt;
    logic starved;

    logic                   cpu_rvalid_q, cpu_rvalid_d;
    logic [COZY_DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic                   vid_rvalid_q, vid_rvalid_d;
    logic [COZY_DATA_W-1:0] vid_rdata_q,  vid_rdata_d;

    // Grant is gated by rst so no write can reach memory mid-reset.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (starved && cpu.req) gnt = GNT_CPU;
            else if (vid.req)       gnt = GNT_VID;
            else if (cpu.req)       gnt = GNT_CPU;
        end
    end

    always_comb begin
        mem_addr = vid.addr;
        mem_din  = '0;
        mem_bwe  = '0;
        if (gnt == GNT_CPU) begin
            mem_addr = cpu.addr;
            mem_din  = cpu.wdata;
            mem_bwe  = cpu.bwe;
        end
    end

    assign cpu.ack = (gnt == GNT_CPU);
    assign vid.ack = (gnt == GNT_VID);

    cozy_mem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .waiting (cpu.req && !cpu.ack),
        .served  (cpu.ack),
        .starved (starved)
    );

    // Read capture: a CPU write leaves cpu_rdata untouched.
    always_comb begin
        cpu_rvalid_d = cpu.ack && (cpu.bwe == '0);
        cpu_rdata_d  = cpu_rvalid_d ? mem_dout : cpu_rdata_q;
        vid_rvalid_d = vid.ack;
        vid_rdata_d  = vid_rvalid_d ? mem_dout : vid_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
        end
    end

    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign vid.rvalid = vid_rvalid_q;
    assign vid.rdata  = vid_rdata_q;
endmodule

// File: tb/tb_cozy_mem_arbiter.sv
// Directed bench for cozy_mem_arbiter with a byte-addressed memory model downstream.
module tb_cozy_mem_arbiter;
    import cozy_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cozy_mem_rw_if cpu();
    cozy_mem_rd_if vid();

    logic [15:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_bwe;

    cozy_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu.slave),
        .vid      (vid.slave),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_bwe  (mem_bwe),
        .mem_dout (mem_dout)
    );

    // Memory model: lane k of din/dout maps to byte addr+k.
    logic [7:0] mem [0:65535];
    logic [15:0] addr_p1;
    assign addr_p1  = mem_addr + 16'd1;
    assign mem_dout = {mem[addr_p1], mem[mem_addr]};
    always @(posedge clk) begin
        if (mem_bwe[0]) mem[mem_addr] <= mem_din[7:0];
        if (mem_bwe[1]) mem[addr_p1]  <= mem_din[15:8];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_acc(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b,
                           input logic [15:0] exp_rd);
        cpu.req = 1'b1; cpu.addr = a; cpu.wdata = d; cpu.bwe = b;
        @(negedge clk);
        chk("cpu_ack", 32'(cpu.ack), 1);
        chk("cpu_mem_bwe", 32'(mem_bwe), 32'(b));
        @(posedge clk); #1;
        cpu.req = 1'b0;
        chk("cpu_rvalid", 32'(cpu.rvalid), (b == 2'b00) ? 1 : 0);
        if (b == 2'b00) chk("cpu_rdata", 32'(cpu.rdata), 32'(exp_rd));
    endtask

    task automatic vid_rd(input logic [15:0] a, input logic [15:0] exp_rd);
        vid.req = 1'b1; vid.addr = a;
        @(negedge clk);
        chk("vid_ack", 32'(vid.ack), 1);
        chk("vid_mem_bwe", 32'(mem_bwe), 0);
        @(posedge clk); #1;
        vid.req = 1'b0;
        chk("vid_rvalid", 32'(vid.rvalid), 1);
        chk("vid_rdata", 32'(vid.rdata), 32'(exp_rd));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        cpu.req = 0; cpu.addr = 0; cpu.wdata = 0; cpu.bwe = 0;
        vid.req = 0; vid.addr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rvalid", 32'(cpu.rvalid), 0);
        chk("rst_vid_rvalid", 32'(vid.rvalid), 0);
        chk("rst_cpu_rdata", 32'(cpu.rdata), 0);
        chk("rst_vid_rdata", 32'(vid.rdata), 0);
        chk("rst_starve", 32'(dut.u_starve.cnt_q), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: CPU write then read
        cpu_acc(16'h0000, 16'h1234, 2'b11, 16'h0);
        cpu_acc(16'h0000, 16'h0000, 2'b00, 16'h1234);

        // 2: byte lanes
        cpu_acc(16'h0002, 16'h5678, 2'b11, 16'h0);
        cpu_acc(16'h0003, 16'h0099, 2'b01, 16'h0);
        vid_rd(16'h0002, 16'h9978);
        vid_rd(16'h0003, 16'h0099);
        chk("cpu_rdata_hold", 32'(cpu.rdata), 32'h1234);

        // 3: simultaneous, CPU not starved
        cpu.req = 1; cpu.addr = 16'h0000; cpu.bwe = 2'b00;
        vid.req = 1; vid.addr = 16'h0002;
        @(negedge clk);
        chk("sim_vid_ack", 32'(vid.ack), 1);
        chk("sim_cpu_ack", 32'(cpu.ack), 0);
        chk("sim_mem_addr", 32'(mem_addr), 32'h0002);
        @(posedge clk); #1;
        vid.req = 0;
        chk("sim_vid_rdata", 32'(vid.rdata), 32'h9978);
        @(negedge clk);
        chk("sim_cpu_ack2", 32'(cpu.ack), 1);
        @(posedge clk); #1;
        cpu.req = 0;
        chk("sim_cpu_rdata", 32'(cpu.rdata), 32'h1234);

        // 4: starvation (prime 0x0004 first)
        cpu_acc(16'h0004, 16'hbeef, 2'b11, 16'h0);
        cpu.req = 1; cpu.addr = 16'h0004; cpu.bwe = 2'b00;
        vid.req = 1; vid.addr = 16'h0000;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("stv_cpu_ack_c%0d", c), 32'(cpu.ack), (c == 4) ? 1 : 0);
            chk($sformatf("stv_vid_ack_c%0d", c), 32'(vid.ack), (c == 4) ? 0 : 1);
            if (c == 5) chk("stv_cnt_clear", 32'(dut.u_starve.cnt_q), 0);
            @(posedge clk); #1;
            if (c != 4) vid.addr = vid.addr + 16'd2;
            if (c == 4) begin
                cpu.req = 0;
                chk("stv_cpu_rvalid", 32'(cpu.rvalid), 1);
                chk("stv_cpu_rdata", 32'(cpu.rdata), 32'hbeef);
            end
        end
        vid.req = 0;
        @(posedge clk); #1;

        // 5: reset clears pending rvalid, blocks a write
        vid.req = 1; vid.addr = 16'h0000;
        @(posedge clk); #1;
        vid.req = 0;
        chk("pre_rst_vid_rvalid", 32'(vid.rvalid), 1);
        rst = 1;
        cpu.req = 1; cpu.addr = 16'h0004; cpu.wdata = 16'hdead; cpu.bwe = 2'b11;
        #1;
        chk("rst_async_rvalid", 32'(vid.rvalid), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_cpu_ack", 32'(cpu.ack), 0);
            chk("rst_mem_bwe", 32'(mem_bwe), 0);
            @(posedge clk); #1;
        end
        cpu.req = 0;
        rst = 0;
        chk("post_rst_vid_rvalid", 32'(vid.rvalid), 0);
        cpu_acc(16'h0004, 16'h0000, 2'b00, 16'hbeef);

        // 6: back-to-back video reads
        vid.req = 1; vid.addr = 16'h0000;
        @(posedge clk); #1;
        vid.addr = 16'h0002;
        chk("b2b_rv0", 32'(vid.rvalid), 1);
        chk("b2b_rd0", 32'(vid.rdata), 32'h1234);
        @(posedge clk); #1;
        vid.addr = 16'h0004;
        chk("b2b_rv1", 32'(vid.rvalid), 1);
        chk("b2b_rd1", 32'(vid.rdata), 32'h9978);
        @(posedge clk); #1;
        vid.req = 0;
        chk("b2b_rv2", 32'(vid.rvalid), 1);
        chk("b2b_rd2", 32'(vid.rdata), 32'hbeef);
        @(posedge clk); #1;
        chk("b2b_rv_end", 32'(vid.rvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
